// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchroniser, ce-paced framing FSM with
// mid-bit sampling, and a valid/ack holding register with overrun flag.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SIZE         = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          i_rx,
  input  logic          i_data_ack,
  output logic [SIZE:0] o_data_byte,
  output logic          o_data_valid,
  output logic          o_active,
  output logic          o_frame_err,
  output logic          o_overrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (SIZE > 0) ? $clog2(SIZE + 1) : 1;

  localparam logic [TW-1:0] HALF_M1   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tcnt_q;
  logic [BW-1:0] bidx_q;
  logic [SIZE:0] shift_q;
  logic          active_q;
  logic          ferr_q;
  logic          good_q;

  logic          rx_meta_q;
  logic          rx_s_q;

  logic [SIZE:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
      good_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      good_q <= 1'b0;
      if (ce) begin
        case (state_q)
          IDLE: begin
            if (!rx_s_q) begin
              state_q  <= START;
              tcnt_q   <= '0;
              active_q <= 1'b1;
            end
          end
          START: begin
            if (tcnt_q == HALF_M1) begin
              tcnt_q <= '0;
              if (!rx_s_q) begin
                state_q <= DATA;
                bidx_q  <= '0;
              end else begin
                // Start bit vanished before its centre: treat as a glitch.
                state_q  <= IDLE;
                active_q <= 1'b0;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
          DATA: begin
            if (tcnt_q == FULL_M1) begin
              shift_q[bidx_q] <= rx_s_q;
              tcnt_q          <= '0;
              if (bidx_q == BIDX_LAST) state_q <= STOP;
              else                     bidx_q  <= bidx_q + BW'(1);
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
          STOP: begin
            if (tcnt_q == FULL_M1) begin
              if (rx_s_q) good_q <= 1'b1;
              else        ferr_q <= 1'b1;
              state_q  <= IDLE;
              tcnt_q   <= '0;
              active_q <= 1'b0;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
          default: begin
            state_q  <= IDLE;
            tcnt_q   <= '0;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // A new byte always lands; it flags overrun only if the previous one is still unconsumed.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (good_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !i_data_ack) ovr_d = 1'b1;
      else if (valid_q)           ovr_d = 1'b0;
    end else if (i_data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data_byte  = data_q;
  assign o_data_valid = valid_q;
  assign o_active     = active_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built 8N1 frames, ack handshakes, overrun,
// framing error, glitch rejection, async reset and a slowed ce.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       i_rx;
  logic       i_data_ack;
  logic [7:0] o_data_byte;
  logic       o_data_valid;
  logic       o_active;
  logic       o_frame_err;
  logic       o_overrun;

  int n_cmp   = 0;
  int n_err   = 0;
  int cediv   = 1;
  int bit_clks = 8;
  int ferr_cnt = 0;
  int act_cnt  = 0;
  int ferr_snap;
  int act_snap;
  bit got;

  uart_rx #(.CLKS_PER_BIT(8), .SIZE(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .i_rx         (i_rx),
    .i_data_ack   (i_data_ack),
    .o_data_byte  (o_data_byte),
    .o_data_valid (o_data_valid),
    .o_active     (o_active),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ce generator: one pulse every cediv clocks.
  initial begin
    int cnt;
    cnt = 0;
    ce  = 1'b1;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1 >= cediv) ? 0 : cnt + 1;
      ce  = (cnt == 0);
    end
  end

  // Event monitors: count frame-error pulse cycles and active cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (o_frame_err) ferr_cnt++;
      if (o_active)    act_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
    i_rx = 1'b1;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    i_data_ack = 1'b1;
    @(negedge clk);
    i_data_ack = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (o_data_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_rx       = 1'b1;
    i_data_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_byte",   32'(o_data_byte),  32'h00);
    chk("rst_valid",  32'(o_data_valid), 32'h0);
    chk("rst_active", 32'(o_active),     32'h0);
    chk("rst_ferr",   32'(o_frame_err),  32'h0);
    chk("rst_ovr",    32'(o_overrun),    32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Case 1: single frame, no ack.
    ferr_snap = ferr_cnt;
    send(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    chk("c1_valid",  32'(o_data_valid), 32'h1);
    chk("c1_byte",   32'(o_data_byte),  32'h55);
    chk("c1_ferr",   32'(ferr_cnt - ferr_snap), 32'h0);
    chk("c1_ovr",    32'(o_overrun),    32'h0);
    chk("c1_active", 32'(o_active),     32'h0);
    ack_pulse();
    chk("c1_ack_valid", 32'(o_data_valid), 32'h0);

    // Case 2: back-to-back frames acked as they arrive.
    fork
      begin
        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
      end
      begin
        wait_valid(got);
        chk("c2_got0",  32'(got),         32'h1);
        chk("c2_byte0", 32'(o_data_byte), 32'hA3);
        chk("c2_ovr0",  32'(o_overrun),   32'h0);
        ack_pulse();
        chk("c2_clr0",  32'(o_data_valid), 32'h0);
        wait_valid(got);
        chk("c2_got1",  32'(got),         32'h1);
        chk("c2_byte1", 32'(o_data_byte), 32'h0F);
        chk("c2_ovr1",  32'(o_overrun),   32'h0);
        ack_pulse();
        chk("c2_clr1",  32'(o_data_valid), 32'h0);
      end
    join
    repeat (4) @(negedge clk);

    // Case 3: second byte overwrites an unacked first one.
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    chk("c3_valid", 32'(o_data_valid), 32'h1);
    chk("c3_byte",  32'(o_data_byte),  32'h22);
    chk("c3_ovr",   32'(o_overrun),    32'h1);
    ack_pulse();
    chk("c3_ack_valid", 32'(o_data_valid), 32'h0);
    chk("c3_ack_ovr",   32'(o_overrun),    32'h0);

    // Case 4: stop bit held low.
    ferr_snap = ferr_cnt;
    send(8'hFF, 1'b0);
    repeat (24) @(negedge clk);
    chk("c4_ferr_cycles", 32'(ferr_cnt - ferr_snap), 32'h1);
    chk("c4_valid",       32'(o_data_valid), 32'h0);
    chk("c4_active",      32'(o_active),     32'h0);

    // Case 5: two-tick glitch is rejected, then a real frame.
    ferr_snap = ferr_cnt;
    act_snap  = act_cnt;
    @(negedge clk);
    i_rx = 1'b0;
    repeat (2) @(negedge clk);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("c5_active_seen", 32'(act_cnt > act_snap), 32'h1);
    chk("c5_active_end",  32'(o_active),     32'h0);
    chk("c5_valid",       32'(o_data_valid), 32'h0);
    chk("c5_ferr",        32'(ferr_cnt - ferr_snap), 32'h0);
    send(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    chk("c5_byte",  32'(o_data_byte),  32'h3C);
    chk("c5_valid2", 32'(o_data_valid), 32'h1);

    // Case 6: async reset mid-DATA with a byte still pending.
    fork
      send(8'h7E, 1'b1);
      begin
        repeat (30) @(negedge clk);
        chk("c6_pre_active", 32'(o_active),     32'h1);
        chk("c6_pre_valid",  32'(o_data_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("c6_byte",   32'(o_data_byte),  32'h00);
        chk("c6_valid",  32'(o_data_valid), 32'h0);
        chk("c6_active", 32'(o_active),     32'h0);
        chk("c6_ferr",   32'(o_frame_err),  32'h0);
        chk("c6_ovr",    32'(o_overrun),    32'h0);
      end
    join
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send(8'h81, 1'b1);
    repeat (2) @(negedge clk);
    chk("c6_post_byte",  32'(o_data_byte),  32'h81);
    chk("c6_post_valid", 32'(o_data_valid), 32'h1);
    ack_pulse();

    // Case 1 again with ce every 4th clock.
    cediv    = 4;
    bit_clks = 32;
    repeat (8) @(negedge clk);
    ferr_snap = ferr_cnt;
    send(8'h55, 1'b1);
    repeat (2) @(negedge clk);
    chk("c7_valid",  32'(o_data_valid), 32'h1);
    chk("c7_byte",   32'(o_data_byte),  32'h55);
    chk("c7_ferr",   32'(ferr_cnt - ferr_snap), 32'h0);
    chk("c7_ovr",    32'(o_overrun),    32'h0);
    chk("c7_active", 32'(o_active),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
